// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: queues 128-bit icache chunks as dwords and presents whole 32/64-bit instructions with their PC.
// Latency: a chunk accepted in cycle N can drive inst_out in cycle N+1; the output is combinational from the buffer head.
// Backpressure: icache ready only when at least 4 dwords are free (registered occupancy); the output holds while not ready.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   icache_rd_resp_{vld_i,rdy_o,dat_i}  icache response {epoch, dwords[127:0]}, dword0 at [31:0] is lowest address
//   inst_out_{vld_o,rdy_i,dat_o}        assembled instruction {pc, is64, instr[63:0]}
//   flush_i, flush_pc_i                 one-cycle redirect strobe and new dword-aligned PC
//   epoch_o                             current fetch epoch
//   occupancy_o                         number of valid dwords held
module inst_fetch_buffer #(
    parameter int DEPTH_DW  = 16,
    parameter int PC_WIDTH  = 48,
    parameter int RESP_SIZE = 129,
    parameter int INST_SIZE = PC_WIDTH + 65
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          icache_rd_resp_vld_i,
    output logic                          icache_rd_resp_rdy_o,
    input  logic [RESP_SIZE-1:0]          icache_rd_resp_dat_i,
    output logic                          inst_out_vld_o,
    input  logic                          inst_out_rdy_i,
    output logic [INST_SIZE-1:0]          inst_out_dat_o,
    input  logic                          flush_i,
    input  logic [PC_WIDTH-1:0]           flush_pc_i,
    output logic                          epoch_o,
    output logic [$clog2(DEPTH_DW):0]     occupancy_o
);

    localparam int AW = $clog2(DEPTH_DW);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH_DW);

    logic [31:0]         mem_q [DEPTH_DW];
    logic [OW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]       occ_q, occ_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                epoch_q, epoch_d;

    logic [AW-1:0]       head_idx, next_idx;
    logic [31:0]         head_dw, next_dw;
    logic                head_is64;
    logic [OW-1:0]       free_dw;
    logic [OW-1:0]       pop_cnt;
    logic                push, pop;

    // Length decode of the head dword. SOP1/SOPC/SOPP share the SOPK
    // top nibble, so their 9-bit opcodes must be tested before SOPK.
    function automatic logic dec_is64(input logic [31:0] h);
        logic r;
        r = 1'b0;
        if (h[31:30] == 2'b11) begin
            r = 1'b1;
        end else if (h[31:30] == 2'b10) begin
            if (h[31:23] == 9'h17F) begin
                r = 1'b0;
            end else if (h[31:23] == 9'h17E) begin
                r = (h[7:0] == 8'hFF) || (h[15:8] == 8'hFF);
            end else if (h[31:23] == 9'h17D) begin
                r = (h[7:0] == 8'hFF);
            end else if (h[31:28] == 4'b1011) begin
                r = 1'b0;
            end else begin
                r = (h[7:0] == 8'hFF) || (h[15:8] == 8'hFF);
            end
        end
        return r;
    endfunction

    always_comb begin
        // Second dword index wraps naturally in AW bits, covering the
        // instruction that straddles the end of the array.
        head_idx  = rd_ptr_q[AW-1:0];
        next_idx  = head_idx + 1'b1;
        head_dw   = mem_q[head_idx];
        next_dw   = mem_q[next_idx];
        head_is64 = dec_is64(head_dw);

        free_dw              = DEPTH_C - occ_q;
        icache_rd_resp_rdy_o = (free_dw >= OW'(4));

        inst_out_vld_o = head_is64 ? (occ_q >= OW'(2)) : (occ_q >= OW'(1));
        inst_out_dat_o = '0;
        if (inst_out_vld_o) begin
            inst_out_dat_o = {pc_q, head_is64, (head_is64 ? next_dw : 32'h0), head_dw};
        end

        // Stale-epoch responses are handshaken but never written.
        push    = icache_rd_resp_vld_i && icache_rd_resp_rdy_o && !flush_i &&
                  (icache_rd_resp_dat_i[RESP_SIZE-1] == epoch_q);
        pop     = inst_out_vld_o && inst_out_rdy_i && !flush_i;
        pop_cnt = head_is64 ? OW'(2) : OW'(1);

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        pc_d     = pc_q;
        epoch_d  = epoch_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
            pc_d     = flush_pc_i;
            epoch_d  = ~epoch_q;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + OW'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + pop_cnt;
                pc_d     = pc_q + (head_is64 ? PC_WIDTH'(8) : PC_WIDTH'(4));
            end
            occ_d = occ_q + (push ? OW'(4) : OW'(0)) - (pop ? pop_cnt : OW'(0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            pc_q     <= '0;
            epoch_q  <= 1'b0;
            for (int i = 0; i < DEPTH_DW; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            pc_q     <= pc_d;
            epoch_q  <= epoch_d;
            if (push) begin
                for (int k = 0; k < 4; k++) begin
                    mem_q[wr_ptr_q[AW-1:0] + AW'(k)] <= icache_rd_resp_dat_i[32*k +: 32];
                end
            end
        end
    end

    assign epoch_o     = epoch_q;
    assign occupancy_o = occ_q;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer: table of per-cycle vectors plus hand sequences for multi-cycle corners.
// Latency: n/a.
// Backpressure: inst_out ready driven per vector / sequence.
module tb_inst_fetch_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_vld;
    logic         in_rdy;
    logic [128:0] in_dat;
    logic         out_vld;
    logic         out_rdy;
    logic [112:0] out_dat;
    logic         flush;
    logic [47:0]  flush_pc;
    logic         epoch;
    logic [4:0]   occ;

    int checks   = 0;
    int failures = 0;

    inst_fetch_buffer dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .icache_rd_resp_vld_i (in_vld),
        .icache_rd_resp_rdy_o (in_rdy),
        .icache_rd_resp_dat_i (in_dat),
        .inst_out_vld_o       (out_vld),
        .inst_out_rdy_i       (out_rdy),
        .inst_out_dat_o       (out_dat),
        .flush_i              (flush),
        .flush_pc_i           (flush_pc),
        .epoch_o              (epoch),
        .occupancy_o          (occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         vld;
        logic [128:0] dat;
        logic         ordy;
        logic         irdy;
        logic         ovld;
        logic [112:0] odat;
        logic [4:0]   occ;
    } vec_t;

    vec_t vt[18];

    function automatic logic [128:0] mkresp(input logic ep, input logic [31:0] d0, input logic [31:0] d1,
                                            input logic [31:0] d2, input logic [31:0] d3);
        return {ep, d3, d2, d1, d0};
    endfunction

    function automatic logic [112:0] mko(input logic [47:0] pc, input logic w, input logic [63:0] ins);
        return {pc, w, ins};
    endfunction

    function automatic vec_t mkv(input logic vld, input logic [128:0] dat, input logic ordy,
                                 input logic irdy, input logic ovld, input logic [112:0] odat,
                                 input logic [4:0] o);
        vec_t v;
        v.vld = vld; v.dat = dat; v.ordy = ordy;
        v.irdy = irdy; v.ovld = ovld; v.odat = odat; v.occ = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [128:0] d);
        in_vld = 1'b1;
        in_dat = d;
        tick();
        in_vld = 1'b0;
    endtask

    task automatic pop_n(input int n);
        out_rdy = 1'b1;
        repeat (n) tick();
        out_rdy = 1'b0;
    endtask

    logic [128:0] r1;

    initial begin
        rst_n = 1'b0; in_vld = 1'b0; in_dat = '0; out_rdy = 1'b0;
        flush = 1'b0; flush_pc = '0;
        r1 = mkresp(1'b0, 32'hBF800000, 32'h81000102, 32'h7E000280, 32'h00000000);

        #3;
        chk("rst_occ",   occ,     0);
        chk("rst_ovld",  out_vld, 0);
        chk("rst_odat",  out_dat, 0);
        chk("rst_epoch", epoch,   0);
        chk("rst_irdy",  in_rdy,  1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic stream, SOP2 literal, SALU decode variants, push+pop in one cycle.
        vt[0]  = mkv(1, r1, 1, 1, 0, '0, 0);
        vt[1]  = mkv(0, '0, 1, 1, 1, mko(0,  0, 64'hBF800000), 4);
        vt[2]  = mkv(0, '0, 1, 1, 1, mko(4,  0, 64'h81000102), 3);
        vt[3]  = mkv(0, '0, 1, 1, 1, mko(8,  0, 64'h7E000280), 2);
        vt[4]  = mkv(0, '0, 0, 1, 1, mko(12, 0, 64'h0), 1);
        vt[5]  = mkv(0, '0, 1, 1, 1, mko(12, 0, 64'h0), 1);
        vt[6]  = mkv(1, mkresp(0, 32'h810002FF, 32'h12345678, 32'h3, 32'h4), 1, 1, 0, '0, 0);
        vt[7]  = mkv(0, '0, 1, 1, 1, mko(16, 1, 64'h12345678_810002FF), 4);
        vt[8]  = mkv(0, '0, 1, 1, 1, mko(24, 0, 64'h3), 2);
        vt[9]  = mkv(0, '0, 1, 1, 1, mko(28, 0, 64'h4), 1);
        vt[10] = mkv(0, '0, 0, 1, 0, '0, 0);
        vt[11] = mkv(1, mkresp(0, 32'hBE80FF00, 32'hB00000FF, 32'hBE8000FF, 32'h11111111), 1, 1, 0, '0, 0);
        vt[12] = mkv(1, mkresp(0, 32'hBF00FF00, 32'h22222222, 32'hC0000000, 32'h33333333), 1, 1, 1,
                     mko(32, 0, 64'hBE80FF00), 4);
        vt[13] = mkv(0, '0, 1, 1, 1, mko(36, 0, 64'hB00000FF), 7);
        vt[14] = mkv(0, '0, 1, 1, 1, mko(40, 1, 64'h11111111_BE8000FF), 6);
        vt[15] = mkv(0, '0, 1, 1, 1, mko(48, 1, 64'h22222222_BF00FF00), 4);
        vt[16] = mkv(0, '0, 1, 1, 1, mko(56, 1, 64'h33333333_C0000000), 2);
        vt[17] = mkv(0, '0, 0, 1, 0, '0, 0);

        for (int i = 0; i < 18; i++) begin
            in_vld  = vt[i].vld;
            in_dat  = vt[i].dat;
            out_rdy = vt[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d_irdy", i), in_rdy,  vt[i].irdy);
            chk($sformatf("v%0d_ovld", i), out_vld, vt[i].ovld);
            chk($sformatf("v%0d_occ", i),  occ,     vt[i].occ);
            if (vt[i].ovld) chk($sformatf("v%0d_odat", i), out_dat, vt[i].odat);
            tick();
        end
        in_vld = 1'b0; out_rdy = 1'b0;

        // Fill to full with output stalled; pc=64, pointers at index 0.
        for (int c = 0; c < 4; c++) begin
            in_vld = 1'b1;
            in_dat = mkresp(0, 32'h100 + 32'(4*c), 32'h101 + 32'(4*c), 32'h102 + 32'(4*c), 32'h103 + 32'(4*c));
            @(negedge clk);
            chk($sformatf("fill%0d_irdy", c), in_rdy, 1);
            tick();
        end
        in_vld = 1'b0;
        @(negedge clk);
        chk("full_occ",  occ,    16);
        chk("full_irdy", in_rdy, 0);
        pop_n(1);
        @(negedge clk);
        chk("free1_occ",  occ,    15);
        chk("free1_irdy", in_rdy, 0);
        pop_n(2);
        @(negedge clk);
        chk("free3_irdy", in_rdy, 0);
        pop_n(1);
        @(negedge clk);
        chk("free4_occ",  occ,     12);
        chk("free4_irdy", in_rdy,  1);
        chk("free4_odat", out_dat, mko(80, 0, 64'h104));

        // Flush with a same-cycle stale response and same-cycle pop request.
        flush = 1'b1; flush_pc = 48'h1000; out_rdy = 1'b1;
        in_vld = 1'b1; in_dat = mkresp(0, 32'h9, 32'h9, 32'h9, 32'h9);
        tick();
        flush = 1'b0; out_rdy = 1'b0; in_vld = 1'b0;
        @(negedge clk);
        chk("flush_occ",   occ,     0);
        chk("flush_epoch", epoch,   1);
        chk("flush_ovld",  out_vld, 0);
        push1(mkresp(0, 32'hA, 32'hB, 32'hC, 32'hD));
        @(negedge clk);
        chk("stale_occ", occ, 0);
        push1(mkresp(1, 32'hA, 32'hB, 32'hC, 32'hD));
        @(negedge clk);
        chk("redir_odat", out_dat, mko(48'h1000, 0, 64'hA));
        chk("redir_occ",  occ,     4);

        // Walk the head to index 15 with a 64-bit SOP2 there, literal wraps to index 0.
        pop_n(4);
        push1(mkresp(1, 32'h200, 32'h201, 32'h202, 32'h203));
        push1(mkresp(1, 32'h204, 32'h205, 32'h206, 32'h207));
        push1(mkresp(1, 32'h208, 32'h209, 32'h20A, 32'h810002FF));
        pop_n(11);
        @(negedge clk);
        chk("split_hold_ovld", out_vld, 0);
        chk("split_hold_occ",  occ,     1);
        push1(mkresp(1, 32'hCAFEF00D, 32'h5, 32'h6, 32'h7));
        @(negedge clk);
        chk("wrap_ovld", out_vld, 1);
        chk("wrap_odat", out_dat, mko(48'h103C, 1, 64'hCAFEF00D_810002FF));
        chk("wrap_occ",  occ,     5);
        pop_n(1);
        @(negedge clk);
        chk("after_wrap_odat", out_dat, mko(48'h1044, 0, 64'h5));
        chk("after_wrap_occ",  occ,     3);
        push1(mkresp(1, 32'h300, 32'h301, 32'h302, 32'h303));
        @(negedge clk);
        chk("pre_rst_occ", occ, 7);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_occ",   occ,     0);
        chk("arst_ovld",  out_vld, 0);
        chk("arst_odat",  out_dat, 0);
        chk("arst_epoch", epoch,   0);
        chk("arst_irdy",  in_rdy,  1);
        tick();
        rst_n = 1'b1;
        push1(r1);
        @(negedge clk);
        chk("post_rst_odat", out_dat, mko(0, 0, 64'hBF800000));
        chk("post_rst_occ",  occ,     4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
